// File: rtl/uart_rx_fifo_16550.sv
// Receive FIFO for the 16550-compatible UART.
// Stores {bi, fe, pe, data} per received character. The head is read first-word fall-through.
// Also produces overrun, trigger-level, error-in-FIFO and character-timeout status.
// Supports DEPTH-entry FIFO mode and single-holding-register (16450) mode.
// Optional feature: define RX_FIFO_TIMEOUT_EN to build the character-timeout idle counter.
// Without it, timeout is tied low.
module uart_rx_fifo_16550 #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pe_in,
   input  logic       fe_in,
   input  logic       bi_in,
   input  logic       pop,
   input  logic       lsr_rd,
   input  logic       fifo_en,
   input  logic       clr,
   input  logic [1:0] trig_lvl,
   output logic [7:0] dout,
   output logic       dout_pe,
   output logic       dout_fe,
   output logic       dout_bi,
   output logic       empty,
   output logic       full,
   output logic [4:0] level,
   output logic       overrun,
   output logic       err_in_fifo,
   output logic       trig,
   output logic       timeout
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   logic [10:0]      mem_q [DEPTH];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  err_cnt_q, err_cnt_d;
   logic             overrun_q, overrun_d;
   logic             fifo_en_q, fifo_en_d;

   logic             mem_we;
   logic [AddrW-1:0] mem_waddr;
   logic [10:0]      mem_wdata;

   logic             flush;
   logic             empty_c;
   logic             full_c;
   logic [10:0]      head;
   logic             head_err;
   logic             new_err;
   logic             do_pop;
   logic             do_push;
   logic             do_ovw;
   logic             ovr_set;
   logic [CntW-1:0]  thr;

   // Decode this cycle's push/pop/flush actions
   always_comb begin
      flush    = clr | (fifo_en != fifo_en_q);
      empty_c  = (count_q == '0);
      full_c   = fifo_en ? (count_q == DepthC) : (count_q == CntW'(1));
      head     = mem_q[rd_ptr_q];
      head_err = |head[10:8];
      new_err  = pe_in | fe_in | bi_in;
      do_pop   = pop & ~empty_c & ~flush;
      // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted
      do_push  = push & ~flush & (~full_c | do_pop);
      ovr_set  = push & ~flush & full_c & ~do_pop;
      // Holding-register mode replaces the held character instead of dropping the new one
      do_ovw   = ovr_set & ~fifo_en;
   end

   // Next-state for pointers, occupancy, error counter and overrun
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_cnt_d = err_cnt_q;
      fifo_en_d = fifo_en;
      mem_we    = do_push | do_ovw;
      mem_waddr = do_ovw ? rd_ptr_q : wr_ptr_q;
      mem_wdata = {bi_in, fe_in, pe_in, din};
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         err_cnt_d = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
         end
         count_d   = count_q + CntW'(do_push) - CntW'(do_pop);
         err_cnt_d = err_cnt_q + CntW'((do_push | do_ovw) & new_err)
                               - CntW'((do_pop | do_ovw) & head_err);
      end
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (lsr_rd) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= '0;
         overrun_q <= 1'b0;
         fifo_en_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_cnt_q <= err_cnt_d;
         overrun_q <= overrun_d;
         fifo_en_q <= fifo_en_d;
      end
   end

   // Entry storage; contents are don't-care whenever the occupancy excludes them
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Trigger threshold select
   always_comb begin
      unique case (trig_lvl)
         2'b00:   thr = CntW'(1);
         2'b01:   thr = CntW'(4);
         2'b10:   thr = CntW'(8);
         default: thr = CntW'(14);
      endcase
   end

   assign dout        = empty_c ? 8'h00 : head[7:0];
   assign dout_pe     = ~empty_c & head[8];
   assign dout_fe     = ~empty_c & head[9];
   assign dout_bi     = ~empty_c & head[10];
   assign empty       = empty_c;
   assign full        = full_c;
   assign level       = 5'(count_q);
   assign overrun     = overrun_q;
   assign err_in_fifo = (err_cnt_q != '0);
   assign trig        = fifo_en ? (count_q >= thr) : ~empty_c;

`ifdef RX_FIFO_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   logic [TmoW-1:0] idle_q, idle_d;

   // Idle counter saturates at the last count so timeout holds until the next event
   always_comb begin
      idle_d = idle_q;
      if (flush | push | pop | empty_c | ~fifo_en) begin
         idle_d = '0;
      end else if (idle_q != TmoLast) begin
         idle_d = idle_q + TmoW'(1);
      end
   end

   // Idle counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign timeout = fifo_en & ~empty_c & (idle_q == TmoLast);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_16550.sv
// Self-checking bench for uart_rx_fifo_16550: directed scenarios followed by random traffic.
// Outputs are compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo_16550;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [7:0] din;
   logic       pe_in, fe_in, bi_in;
   logic       pop;
   logic       lsr_rd;
   logic       fifo_en;
   logic       clr;
   logic [1:0] trig_lvl;
   logic [7:0] dout;
   logic       dout_pe, dout_fe, dout_bi;
   logic       empty, full;
   logic [4:0] level;
   logic       overrun, err_in_fifo, trig, timeout;

   always #5 clk = ~clk;

   uart_rx_fifo_16550 #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .din        (din),
      .pe_in      (pe_in),
      .fe_in      (fe_in),
      .bi_in      (bi_in),
      .pop        (pop),
      .lsr_rd     (lsr_rd),
      .fifo_en    (fifo_en),
      .clr        (clr),
      .trig_lvl   (trig_lvl),
      .dout       (dout),
      .dout_pe    (dout_pe),
      .dout_fe    (dout_fe),
      .dout_bi    (dout_bi),
      .empty      (empty),
      .full       (full),
      .level      (level),
      .overrun    (overrun),
      .err_in_fifo(err_in_fifo),
      .trig       (trig),
      .timeout    (timeout)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queue of {bi, fe, pe, data} entries
   logic [10:0] mq[$];
   logic        m_ovr   = 1'b0;
   logic        m_fen_q = 1'b0;
   int          m_idle  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_update();
      logic        fl  = clr || (fifo_en != m_fen_q);
      int          eff = fifo_en ? DEPTH : 1;
      int          nb  = mq.size();
      logic        cp  = pop && (nb > 0);
      logic        ovr_set = 1'b0;
      logic [10:0] ent = {bi_in, fe_in, pe_in, din};
      if (fl) begin
         mq.delete();
      end else if (push) begin
         if (nb < eff || cp) begin
            if (cp) void'(mq.pop_front());
            mq.push_back(ent);
         end else begin
            ovr_set = 1'b1;
            if (!fifo_en) mq[0] = ent;
         end
      end else if (cp) begin
         void'(mq.pop_front());
      end
      if (ovr_set) m_ovr = 1'b1;
      else if (lsr_rd) m_ovr = 1'b0;
      if (fl || push || pop || nb == 0 || !fifo_en) m_idle = 0;
      else m_idle++;
      m_fen_q = fifo_en;
   endtask

   task automatic check_all(input string tag);
      int          n   = mq.size();
      int          eff = fifo_en ? DEPTH : 1;
      int          thr;
      logic        e_err = 1'b0;
      logic        e_tmo;
      logic [10:0] h;
      h = (n > 0) ? mq[0] : 11'd0;
      case (trig_lvl)
         2'd0:    thr = 1;
         2'd1:    thr = 4;
         2'd2:    thr = 8;
         default: thr = 14;
      endcase
      foreach (mq[i]) if (|mq[i][10:8]) e_err = 1'b1;
`ifdef RX_FIFO_TIMEOUT_EN
      e_tmo = fifo_en && (n > 0) && (m_idle >= int'(TMO) - 1);
`else
      e_tmo = 1'b0;
`endif
      check({tag, " empty"},   32'(empty),       32'(n == 0));
      check({tag, " full"},    32'(full),        32'(n == eff));
      check({tag, " level"},   32'(level),       32'(n));
      check({tag, " dout"},    32'(dout),        32'(h[7:0]));
      check({tag, " flags"},   32'({dout_bi, dout_fe, dout_pe}), 32'(h[10:8]));
      check({tag, " overrun"}, 32'(overrun),     32'(m_ovr));
      check({tag, " err"},     32'(err_in_fifo), 32'(e_err));
      check({tag, " trig"},    32'(trig),        32'(fifo_en ? (n >= thr) : (n > 0)));
      check({tag, " timeout"}, 32'(timeout),     32'(e_tmo));
   endtask

   // One clock: drive strobes, take the edge, update the model, compare after the edge
   task automatic step(input logic p, input logic [10:0] e, input logic pp, input logic lr,
                       input logic cl, input string tag);
      push = p;
      {bi_in, fe_in, pe_in, din} = e;
      pop    = pp;
      lsr_rd = lr;
      clr    = cl;
      @(posedge clk);
      model_update();
      #1;
      push = 1'b0; pop = 1'b0; lsr_rd = 1'b0; clr = 1'b0;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; din = 8'h00; pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
      pop = 1'b0; lsr_rd = 1'b0; clr = 1'b0; fifo_en = 1'b1; trig_lvl = 2'd0;
      #2;
      check("rst empty", 32'(empty), 32'd1);
      check("rst level", 32'(level), 32'd0);
      check("rst others", 32'({dout, dout_pe, dout_fe, dout_bi, full, overrun, err_in_fifo,
                               trig, timeout}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      step(0, 11'h000, 0, 0, 0, "idle");

      // Basic FIFO ordering
      step(1, 11'h041, 0, 0, 0, "p41");
      step(1, 11'h042, 0, 0, 0, "p42");
      step(1, 11'h043, 0, 0, 0, "p43");
      check("tp1 level", 32'(level), 32'd3);
      check("tp1 dout", 32'(dout), 32'h41);
      step(0, 11'h000, 1, 0, 0, "pop1");
      check("tp1 pop1", 32'(dout), 32'h42);
      step(0, 11'h000, 1, 0, 0, "pop2");
      check("tp1 pop2", 32'(dout), 32'h43);
      step(0, 11'h000, 1, 0, 0, "pop3");
      check("tp1 empty", 32'({empty, dout}), 32'h100);

      // Fill, overrun, lsr clear, push+pop while full
      for (int k = 0; k < 16; k++) step(1, 11'(8'h60 + k), 0, 0, 0, "fill");
      step(1, 11'h0AA, 0, 0, 0, "pAA");
      check("tp2 full", 32'({full, overrun, level}), 32'({1'b1, 1'b1, 5'd16}));
      step(0, 11'h000, 0, 1, 0, "lsr");
      check("tp2 ovr clr", 32'(overrun), 32'd0);
      step(1, 11'h077, 1, 0, 0, "pushpop");
      check("tp3 level", 32'({overrun, level}), 32'({1'b0, 5'd16}));
      for (int k = 0; k < 15; k++) step(0, 11'h000, 1, 0, 0, "drain");
      check("tp3 new head", 32'(dout), 32'h77);
      step(0, 11'h000, 1, 0, 0, "drain last");

      // Error flag tracking
      step(1, 11'h011, 0, 0, 0, "p11");
      step(1, 11'h022, 0, 0, 0, "p22");
      step(1, {3'b010, 8'h55}, 0, 0, 0, "p55fe");
      check("tp4 err", 32'(err_in_fifo), 32'd1);
      step(0, 11'h000, 1, 0, 0, "e pop1");
      check("tp4 fe not head", 32'(dout_fe), 32'd0);
      step(0, 11'h000, 1, 0, 0, "e pop2");
      check("tp4 fe head", 32'({dout_fe, dout}), 32'h155);
      step(0, 11'h000, 1, 0, 0, "e pop3");
      check("tp4 err clr", 32'({err_in_fifo, dout_fe}), 32'd0);

      // Trigger level and flush priority
      trig_lvl = 2'd1;
      for (int k = 1; k <= 3; k++) step(1, 11'(k), 0, 0, 0, "trig fill");
      check("tp5 trig3", 32'(trig), 32'd0);
      step(1, 11'h004, 0, 0, 0, "trig4");
      check("tp5 trig4", 32'(trig), 32'd1);
      step(1, 11'h0EE, 0, 0, 1, "clr+push");
      check("tp5 clr", 32'({empty, level}), 32'({1'b1, 5'd0}));

`ifdef RX_FIFO_TIMEOUT_EN
      step(1, 11'h099, 0, 0, 0, "tmo push");
      for (int k = 0; k < 14; k++) step(0, 11'h000, 0, 0, 0, "tmo idle");
      check("tp6 tmo early", 32'(timeout), 32'd0);
      step(0, 11'h000, 0, 0, 0, "tmo idle15");
      check("tp6 tmo", 32'(timeout), 32'd1);
      step(0, 11'h000, 1, 0, 0, "tmo pop");
      check("tp6 tmo clr", 32'(timeout), 32'd0);
`endif

      // Single-register mode
      fifo_en = 1'b0;
      step(0, 11'h000, 0, 0, 0, "mode flush");
      step(1, {3'b001, 8'h10}, 0, 0, 0, "s p10");
      check("sr full", 32'({full, level}), 32'({1'b1, 5'd1}));
      step(1, 11'h020, 0, 0, 0, "s p20");
      check("sr ovw", 32'({overrun, err_in_fifo, dout}), 32'({1'b1, 1'b0, 8'h20}));
      step(1, 11'h030, 1, 0, 0, "s pushpop");
      check("sr pushpop", 32'({overrun, level, dout}), 32'({1'b1, 5'd1, 8'h30}));
      for (int k = 0; k < 20; k++) step(0, 11'h000, 0, 0, 0, "s idle");
      check("sr no tmo", 32'(timeout), 32'd0);
      step(0, 11'h000, 1, 1, 0, "s pop lsr");

      // Asynchronous reset mid-operation
      fifo_en = 1'b1;
      for (int k = 0; k < 17; k++) step(1, {3'b100, 8'(k)}, 0, 0, 0, "pre rst");
      rst = 1'b1;
      #2;
      check("arst", 32'({empty, level, overrun, err_in_fifo, dout, full}),
            32'({1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0}));
      mq.delete(); m_ovr = 1'b0; m_fen_q = 1'b0; m_idle = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      step(0, 11'h000, 0, 0, 0, "post rst");

      // Random traffic with push-heavy, pop-heavy and mostly-idle phases
      for (int i = 0; i < 3000; i++) begin
         int unsigned ph = (i / 250) % 3;
         int unsigned pp = (ph == 0) ? 70 : (ph == 1) ? 25 : 5;
         int unsigned qp = (ph == 0) ? 20 : (ph == 1) ? 70 : 5;
         logic [10:0] e;
         if ($urandom_range(0, 199) == 0) fifo_en = ~fifo_en;
         if ($urandom_range(0, 49) == 0) trig_lvl = 2'($urandom_range(0, 3));
         e[7:0]  = 8'($urandom);
         e[10:8] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         step($urandom_range(0, 99) < pp, e, $urandom_range(0, 99) < qp,
              $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
